// File: rtl/xbus_uart_pkg.sv
// Shared definitions for the xbus UART: register offsets, STATUS bit
// positions, FSM state encodings and divisor helpers.
package xbus_uart_pkg;

    // Register offsets (xbus_addr[3:2])
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_DIV    = 2'd3;

    // STATUS read layout
    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_TX_BUSY  = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_FERR     = 5;

    // STATUS write-one-to-clear bits (the clear bit for overrun is not at
    // its read position; software writes 0x08 to clear it)
    localparam int ST_OVERRUN_CLR = 3;
    localparam int ST_FERR_CLR    = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A programmed divisor of zero behaves as one clock per bit
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    // Half a bit period, floored, never less than one clock
    function automatic logic [15:0] half_div(input logic [15:0] d);
        logic [15:0] h;
        h = eff_div(d) >> 1;
        return (h == 16'd0) ? 16'd1 : h;
    endfunction

endpackage

// File: rtl/xbus_uart_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra wrap
// bit so full/empty are distinguished without a counter. A push while full
// is dropped; a pop while empty is ignored.
module sync_fifo #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] din,
    output logic [DATAW-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Head entry is presented directly so the consumer can pop and load
    // in the same cycle.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer update; full/empty are sampled before the edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbus_uart.sv
// Memory-mapped 8N1 UART on the xbus. Four word registers in a 16-byte
// window; reads are combinational, writes and read side effects commit at
// the clock edge. TX is fed from a small FIFO, RX lands in a one-byte
// buffer whose valid flag drives irq.
module xbus_uart
    import xbus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          TX_DEPTH  = 4,
    parameter logic [15:0] DIV_RST   = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xbus_as,
    input  logic        xbus_we,
    input  logic [3:0]  xbus_be,
    input  logic [31:0] xbus_addr,
    input  logic [31:0] xbus_wdata,
    output logic [31:0] xbus_rdata,
    output logic        uart_txd,
    input  logic        uart_rxd,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       rd_en;

    assign sel     = xbus_as && (xbus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = xbus_addr[3:2];
    assign wr_en   = sel && xbus_we;
    assign rd_en   = sel && !xbus_we;

    logic unused_bits;
    assign unused_bits = ^{xbus_wdata[31:16], xbus_addr[1:0], xbus_be[3:2]};

    // ------------------------------------------------------------------
    // Registers and status
    // ------------------------------------------------------------------
    logic [15:0] div_reg;
    logic [15:0] div_eff;
    logic [15:0] div_half;

    tx_state_t   tx_state_reg;
    logic [15:0] tx_cnt_reg;
    logic [2:0]  tx_bit_reg;
    logic [7:0]  tx_shift_reg;
    logic        txd_reg;

    rx_state_t   rx_state_reg;
    logic [15:0] rx_cnt_reg;
    logic [2:0]  rx_bit_reg;
    logic [7:0]  rx_shift_reg;
    logic [7:0]  rx_byte_reg;
    logic        rx_valid_reg;
    logic        overrun_reg;
    logic        ferr_reg;

    logic        rx_sync1_reg;
    logic        rx_sync2_reg;
    logic        rx_prev_reg;

    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        tx_busy;

    logic        rx_rd_clear;
    logic        ovr_clear;
    logic        ferr_clear;

    assign div_eff  = eff_div(div_reg);
    assign div_half = half_div(div_reg);

    assign fifo_push   = wr_en && (reg_sel == UART_TXDATA) && xbus_be[0];
    assign rx_rd_clear = rd_en && (reg_sel == UART_RXDATA) && rx_valid_reg;
    assign ovr_clear   = wr_en && (reg_sel == UART_STATUS) && xbus_be[0] &&
                         xbus_wdata[ST_OVERRUN_CLR];
    assign ferr_clear  = wr_en && (reg_sel == UART_STATUS) && xbus_be[0] &&
                         xbus_wdata[ST_FERR_CLR];

    assign tx_busy  = (tx_state_reg != TX_IDLE);
    assign uart_txd = txd_reg;
    assign irq      = rx_valid_reg;

    // Read mux: zero outside the window and for TXDATA
    always_comb begin
        xbus_rdata = 32'd0;
        if (rd_en) begin
            case (reg_sel)
                UART_RXDATA: xbus_rdata = {24'd0, rx_byte_reg};
                UART_STATUS: begin
                    xbus_rdata[ST_TX_FULL]  = fifo_full;
                    xbus_rdata[ST_TX_EMPTY] = fifo_empty;
                    xbus_rdata[ST_RX_VALID] = rx_valid_reg;
                    xbus_rdata[ST_TX_BUSY]  = tx_busy;
                    xbus_rdata[ST_OVERRUN]  = overrun_reg;
                    xbus_rdata[ST_FERR]     = ferr_reg;
                end
                UART_DIV:    xbus_rdata = {16'd0, div_reg};
                default:     xbus_rdata = 32'd0;
            endcase
        end
    end

    // DIVISOR register with per-byte enables
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= DIV_RST;
        end else if (wr_en && (reg_sel == UART_DIV)) begin
            if (xbus_be[0]) div_reg[7:0]  <= xbus_wdata[7:0];
            if (xbus_be[1]) div_reg[15:8] <= xbus_wdata[15:8];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .DATAW (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (xbus_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop exactly when the FSM below loads a new frame
    assign fifo_pop = !fifo_empty &&
                      ((tx_state_reg == TX_IDLE) ||
                       ((tx_state_reg == TX_STOP) && (tx_cnt_reg == 16'd0)));

    // ------------------------------------------------------------------
    // TX FSM: line level is registered from the current state, so the
    // start bit appears one clock after the FSM leaves IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'd0;
            txd_reg      <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_START: txd_reg <= 1'b0;
                TX_DATA:  txd_reg <= tx_shift_reg[0];
                default:  txd_reg <= 1'b1;
            endcase

            case (tx_state_reg)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_shift_reg <= fifo_dout;
                        tx_cnt_reg   <= div_eff - 16'd1;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_reg == 16'd0) begin
                        tx_cnt_reg   <= div_eff - 16'd1;
                        tx_bit_reg   <= 3'd0;
                        tx_state_reg <= TX_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_reg == 16'd0) begin
                        tx_cnt_reg   <= div_eff - 16'd1;
                        tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                        if (tx_bit_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                        end else begin
                            tx_bit_reg <= tx_bit_reg + 3'd1;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_reg == 16'd0) begin
                        if (!fifo_empty) begin
                            // Chain the next frame with no idle gap
                            tx_shift_reg <= fifo_dout;
                            tx_cnt_reg   <= div_eff - 16'd1;
                            tx_state_reg <= TX_START;
                        end else begin
                            tx_state_reg <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg - 16'd1;
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge history, idle-high at reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_sync1_reg <= uart_rxd;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM and status flags. Bus clears are applied first so that a
    // completing byte in the same cycle overrides them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
            rx_byte_reg  <= 8'd0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            if (rx_rd_clear) rx_valid_reg <= 1'b0;
            if (ovr_clear)   overrun_reg  <= 1'b0;
            if (ferr_clear)  ferr_reg     <= 1'b0;

            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync2_reg) begin
                        rx_cnt_reg   <= div_half - 16'd1;
                        rx_state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == 16'd0) begin
                        if (rx_sync2_reg) begin
                            // Line back high at mid-bit: a glitch
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            rx_cnt_reg   <= div_eff - 16'd1;
                            rx_bit_reg   <= 3'd0;
                            rx_state_reg <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                        rx_cnt_reg   <= div_eff - 16'd1;
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 3'd1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == 16'd0) begin
                        rx_state_reg <= RX_IDLE;
                        if (!rx_sync2_reg) begin
                            ferr_reg <= 1'b1;
                        end else if (!rx_valid_reg || rx_rd_clear) begin
                            rx_byte_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                        end else begin
                            overrun_reg <= 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg - 16'd1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_uart.sv
// Randomised scoreboard bench for xbus_uart: bus reads and decoded TX
// frames are checked against expectations queued by the stimulus.
module tb_xbus_uart;

    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam int          TX_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        xbus_as;
    logic        xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr;
    logic [31:0] xbus_wdata;
    logic [31:0] xbus_rdata;
    logic        uart_txd;
    logic        uart_rxd;
    logic        irq;

    always #5 clk = ~clk;

    xbus_uart #(
        .BASE_ADDR (BASE),
        .TX_DEPTH  (TX_DEPTH),
        .DIV_RST   (16'd868)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .xbus_as    (xbus_as),
        .xbus_we    (xbus_we),
        .xbus_be    (xbus_be),
        .xbus_addr  (xbus_addr),
        .xbus_wdata (xbus_wdata),
        .xbus_rdata (xbus_rdata),
        .uart_txd   (uart_txd),
        .uart_rxd   (uart_rxd),
        .irq        (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_exp_q[$];
    int         start_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cur_div = 868;

    // Reference model of the receive side
    logic [7:0] m_rx_byte = 8'd0;
    bit         m_rx_valid = 0;
    bit         m_ovr = 0;
    bit         m_ferr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Read monitor: every read presented on the bus consumes one expectation
    always @(negedge clk) begin
        if (xbus_as === 1'b1 && xbus_we === 1'b0) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", xbus_rdata, 32'hDEAD_BEEF);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check(e.name, xbus_rdata, e.exp);
                $display("read  addr=0x%08h data=0x%08h (%s)", xbus_addr, xbus_rdata, e.name);
            end
        end
    end

    // Serial TX monitor: decodes frames mid-bit and pops the expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                int         d;
                logic [7:0] b;
                logic       stp;
                d = cur_div;
                start_q.push_back(cyc);
                repeat (d / 2) @(negedge clk);
                check("tx_start_bit", {31'd0, uart_txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (d) @(negedge clk);
                stp = uart_txd;
                check("tx_stop_bit", {31'd0, stp}, 32'd1);
                if (tx_exp_q.size() == 0) begin
                    check("tx_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = tx_exp_q.pop_front();
                    check("tx_frame", {24'd0, b}, {24'd0, e});
                    $display("txfrm byte=0x%02h expected=0x%02h div=%0d", b, e, d);
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        xbus_as = 1'b1; xbus_we = 1'b1; xbus_be = be;
        xbus_addr = addr; xbus_wdata = data;
        @(posedge clk); #1;
        xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'd0;
        $display("write addr=0x%08h be=%b data=0x%08h", addr, be, data);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        xbus_as = 1'b1; xbus_we = 1'b0; xbus_be = 4'hF; xbus_addr = addr;
        @(posedge clk); #1;
        xbus_as = 1'b0;
    endtask

    function automatic logic [31:0] model_status();
        return {26'd0, m_ferr, m_ovr, 1'b0, m_rx_valid, 1'b1, 1'b0};
    endfunction

    task automatic set_div(input int d);
        bus_write(BASE + 32'hC, 4'b0011, d);
        cur_div = d;
    endtask

    task automatic wait_tx_done();
        int i;
        i = 0;
        while (tx_exp_q.size() != 0 && i < 20000) begin
            @(posedge clk);
            i++;
        end
        if (tx_exp_q.size() != 0) begin
            check("tx_timeout", tx_exp_q.size(), 0);
            tx_exp_q.delete();
        end
        repeat (3 * cur_div + 4) @(posedge clk);
        #1;
    endtask

    // Back-to-back pushes into an idle transmitter: one byte goes straight
    // into flight, so TX_DEPTH+1 bytes are accepted and the rest dropped.
    task automatic tx_burst(input int k, input string tag);
        int acc;
        acc = (k < TX_DEPTH + 1) ? k : TX_DEPTH + 1;
        start_q.delete();
        for (int i = 0; i < k; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (i < acc) tx_exp_q.push_back(b);
            bus_write(BASE, 4'b0001, {24'd0, b});
        end
        wait_tx_done();
        check({tag, "_nframes"}, start_q.size(), acc);
        for (int i = 1; i < start_q.size(); i++) begin
            check({tag, "_gap"}, start_q[i] - start_q[i-1], 10 * cur_div);
        end
        bus_read(BASE + 32'h8, 32'h02, {tag, "_status_idle"});
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop_ok);
        uart_rxd = 1'b0;
        repeat (cur_div) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (cur_div) @(posedge clk); #1;
        end
        uart_rxd = stop_ok;
        repeat (cur_div) @(posedge clk); #1;
        uart_rxd = 1'b1;
        repeat (2 * cur_div + 4) @(posedge clk); #1;
        if (!stop_ok)         m_ferr = 1;
        else if (!m_rx_valid) begin m_rx_byte = b; m_rx_valid = 1; end
        else                  m_ovr = 1;
        $display("rxfrm byte=0x%02h stop_ok=%0d div=%0d", b, stop_ok, cur_div);
    endtask

    task automatic rx_check(input string tag);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_rx_valid});
        bus_read(BASE + 32'h8, model_status(), {tag, "_status"});
    endtask

    task automatic rx_read(input string tag);
        bus_read(BASE + 32'h4, {24'd0, m_rx_byte}, {tag, "_rxdata"});
        m_rx_valid = 0;
    endtask

    initial begin
        rst = 1'b1; xbus_as = 1'b0; xbus_we = 1'b0; xbus_be = 4'd0;
        xbus_addr = 32'd0; xbus_wdata = 32'd0; uart_rxd = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus_read(BASE + 32'h8, 32'h02, "rst_status");
        bus_read(BASE + 32'hC, 32'd868, "rst_div");

        // Divisor byte lanes and be=0
        set_div(4);
        bus_write(BASE + 32'hC, 4'b0000, 32'h0000_1234);
        bus_read(BASE + 32'hC, 32'd4, "div_be0");
        bus_write(BASE + 32'hC, 4'b0010, 32'h0000_0799);
        bus_read(BASE + 32'hC, 32'h0704, "div_be1");
        set_div(4);

        // Single frame 0xA5: start latency and busy window
        tx_exp_q.push_back(8'hA5);
        bus_write(BASE, 4'b0001, 32'h0000_00A5);
        for (int k = 0; k <= 41; k++) begin
            if (k == 1) check("tx_lat_k1", {31'd0, uart_txd}, 32'd1);
            if (k == 2) check("tx_lat_k2", {31'd0, uart_txd}, 32'd0);
            bus_read(BASE + 32'h8,
                     (k == 0) ? 32'h00 : ((k <= 40) ? 32'h0A : 32'h02),
                     "a5_status");
        end
        wait_tx_done();

        // Overfilled burst, then random bursts at random divisors
        tx_burst(6, "burst6");
        for (int r = 0; r < 5; r++) begin
            set_div($urandom_range(2, 6));
            tx_burst($urandom_range(1, 7), "rburst");
        end

        // Receive path
        set_div(4);
        rx_send(8'h3C, 1'b1);
        rx_check("rx3c");
        rx_read("rx3c");
        rx_check("rx3c_after");

        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        rx_read("ovr");
        rx_check("ovr");
        bus_write(BASE + 32'h8, 4'b0001, 32'h08);
        m_ovr = 0;
        rx_check("ovr_clr");

        rx_send(8'h5A, 1'b0);
        rx_check("ferr");
        bus_write(BASE + 32'h8, 4'b0001, 32'h20);
        m_ferr = 0;
        rx_check("ferr_clr");

        uart_rxd = 1'b0;
        @(posedge clk); #1;
        uart_rxd = 1'b1;
        repeat (30) @(posedge clk); #1;
        rx_check("glitch");

        // Out-of-window access has no effect
        bus_write(BASE + 32'h10, 4'hF, 32'h0000_0055);
        bus_read(BASE + 32'h10, 32'd0, "oob_read");
        bus_read(BASE + 32'h8, model_status(), "oob_status");
        repeat (20) @(posedge clk); #1;
        check("oob_txd", {31'd0, uart_txd}, 32'd1);

        // Random receive traffic against the model
        for (int r = 0; r < 12; r++) begin
            set_div($urandom_range(2, 6));
            rx_send(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            rx_check("rrx");
            if ($urandom_range(0, 1) == 1) begin
                rx_read("rrx");
                rx_check("rrx_rd");
            end
            if ($urandom_range(0, 2) == 0) begin
                bus_write(BASE + 32'h8, 4'b0001, 32'h28);
                m_ovr = 0;
                m_ferr = 0;
                rx_check("rrx_clr");
            end
        end

        repeat (4) @(posedge clk); #1;
        check("rd_queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
